// File: rtl/decode_stage_pkg.sv
// Shared encodings for the RV32I decode stage: opcodes, ALU operation codes,
// result-select codes and the funct3/funct7 to ALU operation mapping.
package decode_stage_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SUB    = 4'b0001,
        ALU_AND    = 4'b0010,
        ALU_OR     = 4'b0011,
        ALU_XOR    = 4'b0100,
        ALU_SLL    = 4'b0101,
        ALU_SRL    = 4'b0110,
        ALU_SRA    = 4'b0111,
        ALU_SLT    = 4'b1000,
        ALU_SLTU   = 4'b1001,
        ALU_PASS_B = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } res_src_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_sel_e;

    // funct7[5] means SUB only for register-register ops; for immediates it
    // is part of the constant, except on shifts where it selects SRA.
    function automatic alu_op_e alu_from_funct(input logic [2:0] funct3,
                                               input logic       funct7_5,
                                               input logic       is_r_type);
        alu_op_e op;
        case (funct3)
            3'b000:  op = (is_r_type && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch, writeback and decoded-output bundle of the decode stage.
// The slave side is the decode stage itself; the master side drives it.
interface decode_stage_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     reg_write_w;
    logic [DATA_WIDTH-1:0]    result_w;
    logic [4:0]               rd_w;
    logic [ADDRESS_WIDTH-1:0] pc_f;
    logic [ADDRESS_WIDTH-1:0] pc_plus4_f;
    logic [DATA_WIDTH-1:0]    instr_f;

    logic                     reg_write_d;
    logic [1:0]               res_src_d;
    logic                     mem_write_d;
    logic                     jump_d;
    logic                     branch_d;
    logic [3:0]               alu_control_d;
    logic [2:0]               funct3_d;
    logic                     alu_src_b_d;
    logic                     alu_src_a_d;
    logic                     adder_src_d;
    logic [DATA_WIDTH-1:0]    rd1_d;
    logic [DATA_WIDTH-1:0]    rd2_d;
    logic [ADDRESS_WIDTH-1:0] pc_d;
    logic [ADDRESS_WIDTH-1:0] pc_plus4_d;
    logic [4:0]               rs1_d;
    logic [4:0]               rs2_d;
    logic [4:0]               rd_d;
    logic [DATA_WIDTH-1:0]    imm_val_d;

    modport slave (
        input  reg_write_w, result_w, rd_w, pc_f, pc_plus4_f, instr_f,
        output reg_write_d, res_src_d, mem_write_d, jump_d, branch_d,
               alu_control_d, funct3_d, alu_src_b_d, alu_src_a_d, adder_src_d,
               rd1_d, rd2_d, pc_d, pc_plus4_d, rs1_d, rs2_d, rd_d, imm_val_d
    );

    modport master (
        output reg_write_w, result_w, rd_w, pc_f, pc_plus4_f, instr_f,
        input  reg_write_d, res_src_d, mem_write_d, jump_d, branch_d,
               alu_control_d, funct3_d, alu_src_b_d, alu_src_a_d, adder_src_d,
               rd1_d, rd2_d, pc_d, pc_plus4_d, rs1_d, rs2_d, rd_d, imm_val_d
    );
endinterface

// File: rtl/decode_stage_reg_file.sv
// 32-entry integer register file with two asynchronous read ports and
// write-through bypass so a same-cycle writeback is visible to decode.
module decode_stage_reg_file #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [4:0]            i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [4:0]            i_raddr1,
    input  logic [4:0]            i_raddr2,
    output logic [DATA_WIDTH-1:0] o_rdata1,
    output logic [DATA_WIDTH-1:0] o_rdata2
);

    logic [DATA_WIDTH-1:0] r_regs [32];
    logic [4:0]            w_raddr [2];
    logic [DATA_WIDTH-1:0] w_rdata [2];
    logic                  w_write_valid;

    assign w_write_valid = i_we && (i_waddr != 5'd0);
    assign w_raddr[0]    = i_raddr1;
    assign w_raddr[1]    = i_raddr2;
    assign o_rdata1      = w_rdata[0];
    assign o_rdata2      = w_rdata[1];

    // Entry 0 is cleared on reset and never written, so it stays zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_write_valid) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_read
            always_comb begin
                if (w_raddr[gi] == 5'd0) begin
                    w_rdata[gi] = '0;
                end else if (w_write_valid && (i_waddr == w_raddr[gi])) begin
                    w_rdata[gi] = i_wdata;
                end else begin
                    w_rdata[gi] = r_regs[w_raddr[gi]];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID pipeline register, control decoder, register
// file read and immediate generation. Outputs follow IF/ID combinationally.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input logic          clk,
    input logic          rst,
    decode_stage_if.slave bus
);

    logic [DATA_WIDTH-1:0]    r_instr;
    logic [ADDRESS_WIDTH-1:0] r_pc;
    logic [ADDRESS_WIDTH-1:0] r_pc_plus4;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr    <= DATA_WIDTH'(NOP_INSTR);
            r_pc       <= '0;
            r_pc_plus4 <= '0;
        end else begin
            r_instr    <= bus.instr_f;
            r_pc       <= bus.pc_f;
            r_pc_plus4 <= bus.pc_plus4_f;
        end
    end

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_funct7_5;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [4:0] w_rd;

    assign w_opcode   = r_instr[6:0];
    assign w_funct3   = r_instr[14:12];
    assign w_funct7_5 = r_instr[30];
    assign w_rs1      = r_instr[19:15];
    assign w_rs2      = r_instr[24:20];
    assign w_rd       = r_instr[11:7];

    logic     w_reg_write;
    res_src_e w_res_src;
    logic     w_mem_write;
    logic     w_jump;
    logic     w_branch;
    alu_op_e  w_alu_op;
    logic     w_src_a;
    logic     w_src_b;
    logic     w_adder_src;
    imm_sel_e w_imm_sel;

    // Unrecognised opcodes fall through with every control bit low.
    always_comb begin
        w_reg_write = 1'b0;
        w_res_src   = RES_ALU;
        w_mem_write = 1'b0;
        w_jump      = 1'b0;
        w_branch    = 1'b0;
        w_alu_op    = ALU_ADD;
        w_src_a     = 1'b0;
        w_src_b     = 1'b0;
        w_adder_src = 1'b0;
        w_imm_sel   = IMM_NONE;
        case (w_opcode)
            OP_R: begin
                w_reg_write = 1'b1;
                w_alu_op    = alu_from_funct(w_funct3, w_funct7_5, 1'b1);
            end
            OP_I_ALU: begin
                w_reg_write = 1'b1;
                w_src_b     = 1'b1;
                w_alu_op    = alu_from_funct(w_funct3, w_funct7_5, 1'b0);
                w_imm_sel   = IMM_I;
            end
            OP_LOAD: begin
                w_reg_write = 1'b1;
                w_res_src   = RES_MEM;
                w_src_b     = 1'b1;
                w_imm_sel   = IMM_I;
            end
            OP_STORE: begin
                w_mem_write = 1'b1;
                w_src_b     = 1'b1;
                w_imm_sel   = IMM_S;
            end
            OP_BRANCH: begin
                w_branch    = 1'b1;
                w_alu_op    = ALU_SUB;
                w_imm_sel   = IMM_B;
            end
            OP_JAL: begin
                w_jump      = 1'b1;
                w_reg_write = 1'b1;
                w_res_src   = RES_PC4;
                w_imm_sel   = IMM_J;
            end
            OP_JALR: begin
                w_jump      = 1'b1;
                w_reg_write = 1'b1;
                w_res_src   = RES_PC4;
                w_adder_src = 1'b1;
                w_imm_sel   = IMM_I;
            end
            OP_LUI: begin
                w_reg_write = 1'b1;
                w_src_b     = 1'b1;
                w_alu_op    = ALU_PASS_B;
                w_imm_sel   = IMM_U;
            end
            OP_AUIPC: begin
                w_reg_write = 1'b1;
                w_src_a     = 1'b1;
                w_src_b     = 1'b1;
                w_imm_sel   = IMM_U;
            end
            default: ;
        endcase
    end

    logic [DATA_WIDTH-1:0] w_imm;

    always_comb begin
        w_imm = '0;
        case (w_imm_sel)
            IMM_I: w_imm = {{(DATA_WIDTH-12){r_instr[31]}}, r_instr[31:20]};
            IMM_S: w_imm = {{(DATA_WIDTH-12){r_instr[31]}}, r_instr[31:25],
                            r_instr[11:7]};
            IMM_B: w_imm = {{(DATA_WIDTH-13){r_instr[31]}}, r_instr[31], r_instr[7],
                            r_instr[30:25], r_instr[11:8], 1'b0};
            IMM_U: w_imm = {{(DATA_WIDTH-32){r_instr[31]}}, r_instr[31:12], 12'b0};
            IMM_J: w_imm = {{(DATA_WIDTH-21){r_instr[31]}}, r_instr[31],
                            r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0};
            default: w_imm = '0;
        endcase
    end

    logic [DATA_WIDTH-1:0] w_rd1;
    logic [DATA_WIDTH-1:0] w_rd2;

    decode_stage_reg_file #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .i_we     (bus.reg_write_w),
        .i_waddr  (bus.rd_w),
        .i_wdata  (bus.result_w),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .o_rdata1 (w_rd1),
        .o_rdata2 (w_rd2)
    );

    assign bus.reg_write_d   = w_reg_write;
    assign bus.res_src_d     = w_res_src;
    assign bus.mem_write_d   = w_mem_write;
    assign bus.jump_d        = w_jump;
    assign bus.branch_d      = w_branch;
    assign bus.alu_control_d = w_alu_op;
    assign bus.funct3_d      = w_funct3;
    assign bus.alu_src_b_d   = w_src_b;
    assign bus.alu_src_a_d   = w_src_a;
    assign bus.adder_src_d   = w_adder_src;
    assign bus.rd1_d         = w_rd1;
    assign bus.rd2_d         = w_rd2;
    assign bus.pc_d          = r_pc;
    assign bus.pc_plus4_d    = r_pc_plus4;
    assign bus.rs1_d         = w_rs1;
    assign bus.rs2_d         = w_rs2;
    assign bus.rd_d          = w_rd;
    assign bus.imm_val_d     = w_imm;

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage: reset state, register file with
// bypass and x0 handling, control decode and immediate formats.
module tb_decode_stage;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    decode_stage_if bus_if ();

    decode_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [31:0] instr, input logic [31:0] pc);
        bus_if.instr_f    = instr;
        bus_if.pc_f       = pc;
        bus_if.pc_plus4_f = pc + 32'd4;
        step();
        $display("instr 0x%08h pc 0x%08h -> rw %0b res %0d mw %0b j %0b br %0b alu %0d imm 0x%08h rd1 0x%08h",
                 instr, pc, bus_if.reg_write_d, bus_if.res_src_d, bus_if.mem_write_d,
                 bus_if.jump_d, bus_if.branch_d, bus_if.alu_control_d,
                 bus_if.imm_val_d, bus_if.rd1_d);
    endtask

    logic [3:0]  r_alu_exp [8];
    logic [31:0] instr_v;

    initial begin
        n_checks = 0;
        n_errors = 0;
        r_alu_exp[0] = 4'b0000; r_alu_exp[1] = 4'b0101;
        r_alu_exp[2] = 4'b1000; r_alu_exp[3] = 4'b1001;
        r_alu_exp[4] = 4'b0100; r_alu_exp[5] = 4'b0110;
        r_alu_exp[6] = 4'b0011; r_alu_exp[7] = 4'b0010;

        // Reset must override a non-NOP fetch word and nonzero PCs.
        rst                = 1'b1;
        bus_if.reg_write_w = 1'b0;
        bus_if.result_w    = 32'h0;
        bus_if.rd_w        = 5'd0;
        bus_if.instr_f     = 32'hFFFF_FFFF;
        bus_if.pc_f        = 32'h44;
        bus_if.pc_plus4_f  = 32'h48;
        step();
        rst = 1'b0;
        check_val("rst_reg_write", 32'(bus_if.reg_write_d), 32'd1);
        check_val("rst_src_b", 32'(bus_if.alu_src_b_d), 32'd1);
        check_val("rst_alu", 32'(bus_if.alu_control_d), 32'd0);
        check_val("rst_imm", bus_if.imm_val_d, 32'd0);
        check_val("rst_pc", bus_if.pc_d, 32'd0);
        check_val("rst_pc4", bus_if.pc_plus4_d, 32'd0);
        check_val("rst_rd", 32'(bus_if.rd_d), 32'd0);

        // addi x1,x0,1 while writing x2
        bus_if.reg_write_w = 1'b1;
        bus_if.rd_w        = 5'd2;
        bus_if.result_w    = 32'h1234_5678;
        apply(32'h0010_0093, 32'h0);
        bus_if.reg_write_w = 1'b0;
        check_val("addi1_reg_write", 32'(bus_if.reg_write_d), 32'd1);
        check_val("addi1_rd", 32'(bus_if.rd_d), 32'd1);
        check_val("addi1_imm", bus_if.imm_val_d, 32'd1);
        check_val("addi1_src_b", 32'(bus_if.alu_src_b_d), 32'd1);
        check_val("addi1_pc4", bus_if.pc_plus4_d, 32'd4);

        // addi x5,x2,0: stored read of x2
        apply(32'h0001_0293, 32'h4);
        check_val("read_x2", bus_if.rd1_d, 32'h1234_5678);
        check_val("read_rs1", 32'(bus_if.rs1_d), 32'd2);
        check_val("read_rs2_x0", bus_if.rd2_d, 32'd0);

        // Same-cycle write to x2 is seen before the edge
        bus_if.reg_write_w = 1'b1;
        bus_if.rd_w        = 5'd2;
        bus_if.result_w    = 32'hCAFE_F00D;
        #1;
        check_val("bypass_x2", bus_if.rd1_d, 32'hCAFE_F00D);
        step();
        bus_if.reg_write_w = 1'b0;
        #1;
        check_val("stored_x2", bus_if.rd1_d, 32'hCAFE_F00D);

        // Write to a different register must not bypass into rs1
        bus_if.reg_write_w = 1'b1;
        bus_if.rd_w        = 5'd3;
        bus_if.result_w    = 32'h1111_1111;
        #1;
        check_val("no_false_bypass", bus_if.rd1_d, 32'hCAFE_F00D);
        step();
        bus_if.reg_write_w = 1'b0;

        // Writes to x0 are dropped, including on the bypass path
        bus_if.reg_write_w = 1'b1;
        bus_if.rd_w        = 5'd0;
        bus_if.result_w    = 32'hFFFF_FFFF;
        apply(32'h0000_0013, 32'h8);
        check_val("x0_bypass", bus_if.rd1_d, 32'd0);
        bus_if.reg_write_w = 1'b0;
        apply(32'h0000_0013, 32'hC);
        check_val("x0_stored", bus_if.rd1_d, 32'd0);

        // addi x4,x3,2
        apply(32'h0021_8213, 32'h10);
        check_val("addi2_src_a", 32'(bus_if.alu_src_a_d), 32'd0);
        check_val("addi2_src_b", 32'(bus_if.alu_src_b_d), 32'd1);
        check_val("addi2_alu", 32'(bus_if.alu_control_d), 32'd0);
        check_val("addi2_imm", bus_if.imm_val_d, 32'd2);
        check_val("addi2_rs1", 32'(bus_if.rs1_d), 32'd3);
        check_val("addi2_rd", 32'(bus_if.rd_d), 32'd4);
        check_val("addi2_rd1", bus_if.rd1_d, 32'h1111_1111);

        // blt x6,x5,0
        apply(32'h0053_4063, 32'h14);
        check_val("blt_branch", 32'(bus_if.branch_d), 32'd1);
        check_val("blt_alu", 32'(bus_if.alu_control_d), 32'b0001);
        check_val("blt_funct3", 32'(bus_if.funct3_d), 32'b100);
        check_val("blt_reg_write", 32'(bus_if.reg_write_d), 32'd0);
        check_val("blt_imm", bus_if.imm_val_d, 32'd0);
        check_val("blt_src_b", 32'(bus_if.alu_src_b_d), 32'd0);
        check_val("blt_rs2", 32'(bus_if.rs2_d), 32'd5);

        // beq x0,x0,-4
        apply(32'hFE00_0EE3, 32'h18);
        check_val("beq_neg_imm", bus_if.imm_val_d, 32'hFFFF_FFFC);

        // lw x4,2(x3)
        apply(32'h0021_A203, 32'h1C);
        check_val("lw_mem_write", 32'(bus_if.mem_write_d), 32'd0);
        check_val("lw_res_src", 32'(bus_if.res_src_d), 32'b01);
        check_val("lw_reg_write", 32'(bus_if.reg_write_d), 32'd1);
        check_val("lw_imm", bus_if.imm_val_d, 32'd2);

        // sw x5,8(x3)
        apply(32'h0051_A423, 32'h20);
        check_val("sw_mem_write", 32'(bus_if.mem_write_d), 32'd1);
        check_val("sw_reg_write", 32'(bus_if.reg_write_d), 32'd0);
        check_val("sw_imm", bus_if.imm_val_d, 32'd8);
        check_val("sw_alu", 32'(bus_if.alu_control_d), 32'd0);

        // jal x0: J immediate = {0, 0x35, 1, 0000000010, 0} = 0x35804
        apply(32'h0053_506F, 32'h10);
        check_val("jal_jump", 32'(bus_if.jump_d), 32'd1);
        check_val("jal_res_src", 32'(bus_if.res_src_d), 32'b10);
        check_val("jal_imm", bus_if.imm_val_d, 32'h0003_5804);
        check_val("jal_pc", bus_if.pc_d, 32'h10);
        check_val("jal_pc4", bus_if.pc_plus4_d, 32'h14);
        check_val("jal_adder_src", 32'(bus_if.adder_src_d), 32'd0);

        // jalr x1,0(x2)
        apply(32'h0001_00E7, 32'h24);
        check_val("jalr_jump", 32'(bus_if.jump_d), 32'd1);
        check_val("jalr_adder_src", 32'(bus_if.adder_src_d), 32'd1);
        check_val("jalr_res_src", 32'(bus_if.res_src_d), 32'b10);

        // addi x1,x0,-1
        apply(32'hFFF0_0093, 32'h28);
        check_val("addi_neg_imm", bus_if.imm_val_d, 32'hFFFF_FFFF);

        // sub x3,x1,x2
        apply(32'h4020_81B3, 32'h2C);
        check_val("sub_alu", 32'(bus_if.alu_control_d), 32'b0001);
        check_val("sub_src_b", 32'(bus_if.alu_src_b_d), 32'd0);
        check_val("sub_imm", bus_if.imm_val_d, 32'd0);

        // srai x3,x1,3
        apply(32'h4030_D193, 32'h30);
        check_val("srai_alu", 32'(bus_if.alu_control_d), 32'b0111);

        // addi x3,x1,0x400: bit 30 set but I-type funct3=000 stays ADD
        apply(32'h4000_8193, 32'h34);
        check_val("addi_b30_alu", 32'(bus_if.alu_control_d), 32'd0);
        check_val("addi_b30_imm", bus_if.imm_val_d, 32'h400);

        // R-type funct3 sweep, funct7=0
        for (int f = 0; f < 8; f++) begin
            instr_v = {7'b0, 5'd2, 5'd1, 3'(f), 5'd3, 7'b0110011};
            apply(instr_v, 32'h40);
            check_val($sformatf("r_alu_f3_%0d", f), 32'(bus_if.alu_control_d),
                      32'(r_alu_exp[f]));
        end

        // lui x5,0x12345
        apply(32'h1234_52B7, 32'h44);
        check_val("lui_imm", bus_if.imm_val_d, 32'h1234_5000);
        check_val("lui_alu", 32'(bus_if.alu_control_d), 32'b1010);
        check_val("lui_src_b", 32'(bus_if.alu_src_b_d), 32'd1);

        // auipc x5,1
        apply(32'h0000_1297, 32'h48);
        check_val("auipc_src_a", 32'(bus_if.alu_src_a_d), 32'd1);
        check_val("auipc_imm", bus_if.imm_val_d, 32'h1000);
        check_val("auipc_reg_write", 32'(bus_if.reg_write_d), 32'd1);

        // Unlisted opcode behaves as a bubble
        apply(32'h0000_007F, 32'h4C);
        check_val("bad_reg_write", 32'(bus_if.reg_write_d), 32'd0);
        check_val("bad_src_b", 32'(bus_if.alu_src_b_d), 32'd0);
        check_val("bad_jump", 32'(bus_if.jump_d), 32'd0);

        // Reset clears the register file
        bus_if.instr_f = 32'h0001_0293;
        rst = 1'b1;
        step();
        rst = 1'b0;
        apply(32'h0001_0293, 32'h50);
        check_val("rst_clears_x2", bus_if.rd1_d, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
